// File: rtl/cache_refill_engine_if.sv
// rtl/cache_refill_engine_if.sv - Signal bundle between the refill engine, the cache controller and memory
// Purpose: groups the miss request, victim description, memory beat bus, fill port and busy flag.
// Modports:
//   slave  - the refill engine (consumes miss/victim/memory responses, drives requests and fill)
//   master - the environment (cache controller + memory side)

interface cache_refill_engine_if #(
  parameter int TAG_BITS       = 18,
  parameter int INDEX_WIDTH    = 8,
  parameter int WAY_WIDTH      = 2,
  parameter int LINE_SIZE_BITS = 512,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32
);

  // miss request and victim description
  logic                      i_miss_valid;
  logic                      o_miss_ready;
  logic [TAG_BITS-1:0]       i_miss_tag;
  logic [INDEX_WIDTH-1:0]    i_miss_index;
  logic [WAY_WIDTH-1:0]      i_victim_way;
  logic                      i_victim_valid;
  logic                      i_victim_dirty;
  logic [TAG_BITS-1:0]       i_victim_tag;
  logic [LINE_SIZE_BITS-1:0] i_victim_line;

  // memory beat bus
  logic                      o_mem_valid;
  logic                      i_mem_ready;
  logic                      o_mem_we;
  logic [ADDRESS_WIDTH-1:0]  o_mem_addr;
  logic [DATA_WIDTH-1:0]     o_mem_wdata;
  logic                      i_mem_rvalid;
  logic [DATA_WIDTH-1:0]     i_mem_rdata;

  // cache array fill port
  logic                      o_fill_valid;
  logic [INDEX_WIDTH-1:0]    o_fill_index;
  logic [WAY_WIDTH-1:0]      o_fill_way;
  logic [TAG_BITS-1:0]       o_fill_tag;
  logic [LINE_SIZE_BITS-1:0] o_fill_line;

  logic                      o_busy;

  modport slave (
    input  i_miss_valid, i_miss_tag, i_miss_index,
    input  i_victim_way, i_victim_valid, i_victim_dirty, i_victim_tag, i_victim_line,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata,
    output o_miss_ready,
    output o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata,
    output o_fill_valid, o_fill_index, o_fill_way, o_fill_tag, o_fill_line,
    output o_busy
  );

  modport master (
    output i_miss_valid, i_miss_tag, i_miss_index,
    output i_victim_way, i_victim_valid, i_victim_dirty, i_victim_tag, i_victim_line,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata,
    input  o_miss_ready,
    input  o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata,
    input  o_fill_valid, o_fill_index, o_fill_way, o_fill_tag, o_fill_line,
    input  o_busy
  );

endinterface

// File: rtl/cache_refill_engine.sv
// rtl/cache_refill_engine.sv - Cache miss service engine: victim write-back, line fetch, array fill
// Purpose: accepts one miss at a time. A valid+dirty victim is first written back beat by beat,
//   then the missing line is fetched with one read request per beat, and finally a single
//   one-cycle fill strobe writes the new line (tag, index, way, data) into the cache array.
// Ports:
//   clk  - clock, all logic on the rising edge
//   rst  - synchronous active-high reset, aborts any miss in flight
//   bus  - cache_refill_engine_if.slave:
//          i_miss_* / i_victim_* / o_miss_ready : miss request and victim description
//          o_mem_* / i_mem_*                    : memory beat request bus and read data return
//          o_fill_*                             : cache array write port
//          o_busy                               : high whenever a miss is being serviced

module cache_refill_engine #(
  parameter int CACHE_LINES     = 256,
  parameter int LINE_SIZE_BYTES = 64,
  parameter int TAG_BITS        = 18,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int WAYS            = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_refill_engine_if.slave bus
);

  localparam int INDEX_WIDTH    = $clog2(CACHE_LINES);
  localparam int LINE_SIZE_BITS = LINE_SIZE_BYTES * 8;
  localparam int OFFSET_WIDTH   = $clog2(LINE_SIZE_BYTES);
  localparam int BEATS          = LINE_SIZE_BITS / DATA_WIDTH;
  localparam int BEAT_WIDTH     = $clog2(BEATS);
  localparam int WAY_WIDTH      = $clog2(WAYS);
  // low address bits below the beat number (byte within a beat)
  localparam int BYTE_BITS      = OFFSET_WIDTH - BEAT_WIDTH;

  localparam logic [BEAT_WIDTH-1:0] BEAT_ZERO = '0;
  localparam logic [BEAT_WIDTH-1:0] BEAT_ONE  = BEAT_WIDTH'(1);
  localparam logic [BEAT_WIDTH-1:0] LAST_BEAT = BEAT_WIDTH'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    FILL    = 3'd4
  } state_t;

  // Byte address of one beat of a line: {tag, index, beat, byte-in-beat = 0}
  function automatic logic [ADDRESS_WIDTH-1:0] beat_addr(
    input logic [TAG_BITS-1:0]    tag,
    input logic [INDEX_WIDTH-1:0] index,
    input logic [BEAT_WIDTH-1:0]  beat
  );
    beat_addr = {tag, index, beat, {BYTE_BITS{1'b0}}};
  endfunction

  // Beat 0 is the least significant slice of the line
  function automatic logic [DATA_WIDTH-1:0] line_beat(
    input logic [LINE_SIZE_BITS-1:0] line,
    input logic [BEAT_WIDTH-1:0]     beat
  );
    line_beat = line[beat*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  state_t                    state;
  logic [BEAT_WIDTH-1:0]     beat;

  // miss context captured at acceptance
  logic [TAG_BITS-1:0]       cap_tag;
  logic [INDEX_WIDTH-1:0]    cap_index;
  logic [WAY_WIDTH-1:0]      cap_way;
  logic [TAG_BITS-1:0]       cap_vtag;
  logic [LINE_SIZE_BITS-1:0] cap_vline;
  logic [LINE_SIZE_BITS-1:0] line_buf;

  // registered outputs
  logic                      miss_ready;
  logic                      busy;
  logic                      mem_valid;
  logic                      mem_we;
  logic [ADDRESS_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic                      fill_valid;
  logic [INDEX_WIDTH-1:0]    fill_index;
  logic [WAY_WIDTH-1:0]      fill_way;
  logic [TAG_BITS-1:0]       fill_tag;
  logic [LINE_SIZE_BITS-1:0] fill_line;

  // Line buffer with the current read beat merged in; lets the last beat go straight
  // into the fill register without an extra cycle.
  logic [LINE_SIZE_BITS-1:0] line_merged;

  always_comb begin
    line_merged = line_buf;
    line_merged[beat*DATA_WIDTH +: DATA_WIDTH] = bus.i_mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat       <= BEAT_ZERO;
      cap_tag    <= '0;
      cap_index  <= '0;
      cap_way    <= '0;
      cap_vtag   <= '0;
      cap_vline  <= '0;
      line_buf   <= '0;
      miss_ready <= 1'b1;
      busy       <= 1'b0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      fill_valid <= 1'b0;
      fill_index <= '0;
      fill_way   <= '0;
      fill_tag   <= '0;
      fill_line  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_miss_valid) begin
            cap_tag    <= bus.i_miss_tag;
            cap_index  <= bus.i_miss_index;
            cap_way    <= bus.i_victim_way;
            cap_vtag   <= bus.i_victim_tag;
            cap_vline  <= bus.i_victim_line;
            beat       <= BEAT_ZERO;
            miss_ready <= 1'b0;
            busy       <= 1'b1;
            mem_valid  <= 1'b1;
            // Only a line that is both valid and modified has to go back to memory.
            if (bus.i_victim_valid && bus.i_victim_dirty) begin
              state     <= WB;
              mem_we    <= 1'b1;
              mem_addr  <= beat_addr(bus.i_victim_tag, bus.i_miss_index, BEAT_ZERO);
              mem_wdata <= line_beat(bus.i_victim_line, BEAT_ZERO);
            end else begin
              state    <= RD_REQ;
              mem_we   <= 1'b0;
              mem_addr <= beat_addr(bus.i_miss_tag, bus.i_miss_index, BEAT_ZERO);
            end
          end
        end

        WB: begin
          // Address/data only move on a completed handshake, so they hold through stalls.
          if (bus.i_mem_ready) begin
            if (beat == LAST_BEAT) begin
              beat     <= BEAT_ZERO;
              state    <= RD_REQ;
              mem_we   <= 1'b0;
              mem_addr <= beat_addr(cap_tag, cap_index, BEAT_ZERO);
            end else begin
              beat      <= beat + BEAT_ONE;
              mem_addr  <= beat_addr(cap_vtag, cap_index, beat + BEAT_ONE);
              mem_wdata <= line_beat(cap_vline, beat + BEAT_ONE);
            end
          end
        end

        RD_REQ: begin
          if (bus.i_mem_ready) begin
            state     <= RD_DATA;
            mem_valid <= 1'b0;
          end
        end

        RD_DATA: begin
          // rvalid is only honoured here; returns seen in any other state are dropped.
          if (bus.i_mem_rvalid) begin
            line_buf <= line_merged;
            if (beat == LAST_BEAT) begin
              beat       <= BEAT_ZERO;
              state      <= FILL;
              fill_valid <= 1'b1;
              fill_index <= cap_index;
              fill_way   <= cap_way;
              fill_tag   <= cap_tag;
              fill_line  <= line_merged;
            end else begin
              beat      <= beat + BEAT_ONE;
              state     <= RD_REQ;
              mem_valid <= 1'b1;
              mem_addr  <= beat_addr(cap_tag, cap_index, beat + BEAT_ONE);
            end
          end
        end

        FILL: begin
          // Fill fields stay at their last value; only the strobe drops.
          fill_valid <= 1'b0;
          state      <= IDLE;
          busy       <= 1'b0;
          miss_ready <= 1'b1;
        end

        default: begin
          state      <= IDLE;
          beat       <= BEAT_ZERO;
          busy       <= 1'b0;
          miss_ready <= 1'b1;
          mem_valid  <= 1'b0;
          fill_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_miss_ready = miss_ready;
  assign bus.o_busy       = busy;
  assign bus.o_mem_valid  = mem_valid;
  assign bus.o_mem_we     = mem_we;
  assign bus.o_mem_addr   = mem_addr;
  assign bus.o_mem_wdata  = mem_wdata;
  assign bus.o_fill_valid = fill_valid;
  assign bus.o_fill_index = fill_index;
  assign bus.o_fill_way   = fill_way;
  assign bus.o_fill_tag   = fill_tag;
  assign bus.o_fill_line  = fill_line;

endmodule
